// File: rtl/reverb_mem_sequencer.sv
// reverb_mem_sequencer: walks x[] in data memory, applies y[n] = x[n] + alpha*y[n-D]
// and writes y[] back into a separate output region of the same memory.
module reverb_mem_sequencer #(
    parameter int unsigned IN_BASE   = 0,
    parameter int unsigned OUT_BASE  = 133405,
    parameter int unsigned N_SAMPLES = 133405,
    parameter int unsigned DELAY     = 4410,
    parameter int unsigned ALPHA     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [6:0]  mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_X, S_CAP_X, S_RD_Y, S_CAP_Y, S_CALC, S_WR, S_DONE
    } state_t;

    localparam logic [31:0] L_IN    = IN_BASE;
    localparam logic [31:0] L_OUT   = OUT_BASE;
    localparam logic [31:0] L_LAST  = N_SAMPLES - 1;
    localparam logic [31:0] L_DELAY = DELAY;
    localparam logic signed [15:0] L_ALPHA = 16'(ALPHA);

    state_t             r_state;
    logic [31:0]        r_n;
    logic [6:0]         r_x;
    logic [6:0]         r_y_del;
    logic signed [15:0] w_prod;
    logic signed [15:0] w_acc;
    logic [6:0]         w_sat;
    logic               w_unused;

    assign w_unused = ^mem_rdata[31:7];

    // arithmetic shift floors the feedback term; the sum is clamped to the 7-bit range
    always_comb begin
        w_prod = $signed({{9{r_y_del[6]}}, r_y_del}) * L_ALPHA;
        w_acc  = $signed({{9{r_x[6]}}, r_x}) + (w_prod >>> 7);
        w_sat  = (w_acc > 16'sd63) ? 7'h3f : (w_acc < -16'sd64) ? 7'h40 : w_acc[6:0];
    end

    // addresses are registered on entry to each state so memory sees them for the whole cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_x       <= '0;
            r_y_del   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RD_X;
                        busy     <= 1'b1;
                        mem_addr <= L_IN + r_n;
                    end
                end
                S_RD_X: r_state <= S_CAP_X;
                S_CAP_X: begin
                    r_x <= mem_rdata[6:0];
                    if (r_n >= L_DELAY) begin
                        r_state  <= S_RD_Y;
                        mem_addr <= L_OUT + r_n - L_DELAY;
                    end else begin
                        r_y_del <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_RD_Y: r_state <= S_CAP_Y;
                S_CAP_Y: begin
                    r_y_del <= mem_rdata[6:0];
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    mem_wdata <= w_sat;
                    mem_addr  <= L_OUT + r_n;
                    mem_we    <= 1'b1;
                    r_state   <= S_WR;
                end
                S_WR: begin
                    mem_we <= 1'b0;
                    if (r_n == L_LAST) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_n      <= r_n + 32'd1;
                        mem_addr <= L_IN + r_n + 32'd1;
                        r_state  <= S_RD_X;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_n     <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reverb_mem_sequencer.sv
// tb_reverb_mem_sequencer: directed echo vectors against a small negedge memory model.
module tb_reverb_mem_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [6:0]  mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [6:0] xin  [8];
    logic [6:0] yexp [8];
    logic [6:0] ymem [8];
    logic [6:0] r7;
    int nvec = 0;
    int nerr = 0;

    reverb_mem_sequencer #(
        .IN_BASE(0), .OUT_BASE(1000), .N_SAMPLES(8), .DELAY(4), .ALPHA(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we && mem_addr >= 32'd1000 && mem_addr < 32'd1008)
            ymem[3'(mem_addr - 32'd1000)] <= mem_wdata;
        r7 = (mem_addr < 32'd8) ? xin[mem_addr[2:0]] :
             (mem_addr >= 32'd1000 && mem_addr < 32'd1008) ? ymem[3'(mem_addr - 32'd1000)] : 7'd0;
        mem_rdata <= {{25{r7[6]}}, r7};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int mode);
        int cyc = 0;
        int wc = 0;
        int rdc = 0;
        bit got_done = 0;
        logic [31:0] pa = mem_addr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200 && !got_done; k++) begin
            cyc++;
            if (mode == 1 && cyc == 10) start = 1'b1;
            else if (mode == 1 && cyc == 11) start = 1'b0;
            if (mem_we) begin
                chk("wr_index", {31'd0, wc > 7}, 32'd0);
                chk("wr_addr", mem_addr, 32'(1000 + wc));
                chk("wr_data", {25'd0, mem_wdata}, {25'd0, yexp[wc[2:0]]});
                wc++;
                if (mode == 2 && wc == 4) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_we", {31'd0, mem_we}, 32'd0);
                    chk("rst_busy", {31'd0, busy}, 32'd0);
                    chk("rst_done", {31'd0, done}, 32'd0);
                    chk("rst_addr", mem_addr, 32'd0);
                    chk("rst_wdata", {25'd0, mem_wdata}, 32'd0);
                    return;
                end
            end else if (mem_addr != pa && mem_addr >= 32'd1000) begin
                chk("rdy_n_ge_d", {31'd0, wc >= 4}, 32'd1);
                chk("rdy_addr", mem_addr, 32'(1000 + wc - 4));
                rdc++;
            end
            pa = mem_addr;
            if (done) begin
                got_done = 1;
                chk("done_cycles", 32'(cyc), 32'd41);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("done_seen", {31'd0, got_done}, 32'd1);
        chk("we_pulses", 32'(wc), 32'd8);
        chk("rdy_count", 32'(rdc), 32'd4);
        @(posedge clk); #1;
        chk("done_single", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("y[%0d]", i), {25'd0, ymem[i]}, {25'd0, yexp[i]});
    endtask

    initial begin
        start = 1'b0;
        rst_n = 1'b1;
        xin   = '{default: 7'd0};
        ymem  = '{default: 7'd0};
        #1 rst_n = 1'b0;
        #10;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_we", {31'd0, mem_we}, 32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        chk("reset_wdata", {25'd0, mem_wdata}, 32'd0);
        rst_n = 1'b1;

        xin  = '{7'd63, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        yexp = '{7'd63, 7'd0, 7'd0, 7'd0, 7'd31, 7'd0, 7'd0, 7'd0};
        run(0);

        xin  = '{7'h40, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        yexp = '{7'h40, 7'd0, 7'd0, 7'd0, 7'h60, 7'd0, 7'd0, 7'd0};
        run(1);

        xin  = '{7'd63, 7'd0, 7'd0, 7'd0, 7'd63, 7'd0, 7'd0, 7'd0};
        yexp = '{7'd63, 7'd0, 7'd0, 7'd0, 7'd63, 7'd0, 7'd0, 7'd0};
        run(0);

        xin  = '{7'h40, 7'd0, 7'd0, 7'd0, 7'h40, 7'd0, 7'd0, 7'd0};
        yexp = '{7'h40, 7'd0, 7'd0, 7'd0, 7'h40, 7'd0, 7'd0, 7'd0};
        run(0);

        xin  = '{7'd63, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        yexp = '{7'd63, 7'd0, 7'd0, 7'd0, 7'd31, 7'd0, 7'd0, 7'd0};
        run(2);
        #24 rst_n = 1'b1;

        // 10,-5,20,0,3,7,-1,-64 -> 10,-5,20,0,8,4,9,-64 (floor of -2.5 is -3)
        xin  = '{7'd10, 7'h7b, 7'd20, 7'd0, 7'd3, 7'd7, 7'h7f, 7'h40};
        yexp = '{7'd10, 7'h7b, 7'd20, 7'd0, 7'd8, 7'd4, 7'd9, 7'h40};
        run(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
